// File: rtl/shift_sequencer_pkg.sv
// Purpose : shared definitions for the multi-step shift sequencer.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
//
// Contents: default widths and the 2-bit sequencer FSM state encoding.
package shift_sequencer_pkg;

    localparam int N_DEFAULT = 4;   // data width, must match the attached Shifter
    localparam int A_DEFAULT = 3;   // shift-amount field width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/shift_sequencer_step_counter.sv
// Purpose : loadable A-bit down counter tracking remaining shift steps.
// Latency : load/decrement take effect on the next rising edge.
// Backpr. : none; the owner decides when to load or decrement.
//
// Ports:
//   i_clock, i_reset      clock, async active-low reset (count -> 0)
//   i_load, i_load_value  load a new step count (load wins over decrement)
//   i_dec                 decrement by one
//   o_is_one              count is exactly 1 (the step in flight is the last)
module shift_sequencer_step_counter #(
    parameter int A = 3
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [A-1:0] i_load_value,
    input  logic         i_dec,
    output logic         o_is_one
);

    logic [A-1:0] count_q;
    logic [A-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_value;
        end else if (i_dec) begin
            count_d = count_q - A'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_is_one = (count_q == A'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Purpose : multi-step front end for a single-step Shifter; chains AMOUNT one-bit steps.
// Latency : amount 0 -> done one cycle after accept; amount K -> K*(1 + Shifter latency) + 1.
// Backpr. : o_ready only in IDLE; commands offered while busy stay pending upstream.
//
// Ports:
//   i_clock, i_reset                 clock, async active-low reset
//   i_valid/o_ready, i_left, i_rotate, i_amount, i_value   command handshake and fields
//   i_abort                          cancel in-flight command (no o_done)
//   o_done, o_result                 completion pulse and final value (result holds)
//   o_shift_start/left/rotate/value  drive the Shifter's inputs
//   i_shift_finished, i_shift_value  Shifter completion and result
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int A = A_DEFAULT
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_left,
    input  logic         i_rotate,
    input  logic [A-1:0] i_amount,
    input  logic [N-1:0] i_value,
    input  logic         i_abort,
    output logic         o_done,
    output logic [N-1:0] o_result,
    output logic         o_shift_start,
    output logic         o_shift_left,
    output logic         o_shift_rotate,
    output logic [N-1:0] o_shift_value,
    input  logic         i_shift_finished,
    input  logic [N-1:0] i_shift_value
);

    seq_state_e   state_q;
    logic [N-1:0] work_q;
    logic         left_q;
    logic         rotate_q;
    logic         start_q;
    logic         done_q;
    logic [N-1:0] result_q;

    logic         accept;
    logic         step_done;
    logic         last_step;

    // Abort has priority over a new command, even while idle.
    assign accept    = (state_q == ST_IDLE) && i_valid && !i_abort;
    // Completions outside WAIT (e.g. stale ones after an abort) are dropped.
    assign step_done = (state_q == ST_WAIT) && i_shift_finished && !i_abort;

    shift_sequencer_step_counter #(
        .A (A)
    ) u_step_counter (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_load       (accept),
        .i_load_value (i_amount),
        .i_dec        (step_done),
        .o_is_one     (last_step)
    );

    // Outputs are registered: start/done are set on the edge that enters
    // ISSUE/DONE so each is high for exactly the one cycle spent there.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            left_q   <= 1'b0;
            rotate_q <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        work_q   <= i_value;
                        left_q   <= i_left;
                        rotate_q <= i_rotate;
                        if (i_amount == '0) begin
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            result_q <= i_value;
                        end else begin
                            state_q <= ST_ISSUE;
                            start_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q <= i_abort ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_abort) begin
                        state_q <= ST_IDLE;
                    end else if (i_shift_finished) begin
                        work_q <= i_shift_value;
                        if (last_step) begin
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            result_q <= i_shift_value;
                        end else begin
                            state_q <= ST_ISSUE;
                            start_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready        = (state_q == ST_IDLE);
    // done_q is already high while in DONE; an abort in that same cycle must
    // still swallow the pulse, hence the gate on the live abort input.
    assign o_done         = done_q && !i_abort;
    assign o_result       = result_q;
    assign o_shift_start  = start_q;
    assign o_shift_left   = left_q;
    assign o_shift_rotate = rotate_q;
    assign o_shift_value  = work_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Purpose : bench for shift_sequencer with a behavioural one-bit Shifter of random latency.
// Latency : n/a.
// Backpr. : n/a.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic       left = 1'b0;
    logic       rotate = 1'b0;
    logic [2:0] amt = 3'd0;
    logic [3:0] value = 4'd0;
    logic       abort = 1'b0;
    logic       force_fin = 1'b0;

    logic       ready;
    logic       done;
    logic [3:0] result;
    logic       sh_start;
    logic       sh_left;
    logic       sh_rot;
    logic [3:0] sh_value;
    logic       sh_fin;

    // Shifter model state
    logic       sh_busy = 1'b0;
    int         sh_cnt = 0;
    logic [3:0] sh_res = 4'd0;
    logic       sh_fin_q = 1'b0;
    logic [3:0] sh_val_q = 4'd0;

    // Monitor state
    int         start_cnt = 0;
    int         done_cnt = 0;
    int         width_viol = 0;
    logic       prev_start = 1'b0;
    logic       prev_done = 1'b0;

    int         total = 0;
    int         bad = 0;

    assign sh_fin = sh_fin_q | force_fin;

    shift_sequencer #(
        .N (4),
        .A (3)
    ) dut (
        .i_clock          (clk),
        .i_reset          (rst_n),
        .i_valid          (valid),
        .o_ready          (ready),
        .i_left           (left),
        .i_rotate         (rotate),
        .i_amount         (amt),
        .i_value          (value),
        .i_abort          (abort),
        .o_done           (done),
        .o_result         (result),
        .o_shift_start    (sh_start),
        .o_shift_left     (sh_left),
        .o_shift_rotate   (sh_rot),
        .o_shift_value    (sh_value),
        .i_shift_finished (sh_fin),
        .i_shift_value    (sh_val_q)
    );

    always #5 clk = ~clk;

    // One-bit Shifter: samples on start, answers 1..3 cycles later.
    always @(posedge clk) begin
        sh_fin_q <= 1'b0;
        if (sh_start) begin
            sh_busy <= 1'b1;
            sh_cnt  <= int'($urandom_range(0, 2));
            sh_res  <= sh_left ? {sh_value[2:0], sh_rot & sh_value[3]}
                               : {sh_rot & sh_value[0], sh_value[3:1]};
        end else if (sh_busy) begin
            if (sh_cnt == 0) begin
                sh_fin_q <= 1'b1;
                sh_val_q <= sh_res;
                sh_busy  <= 1'b0;
            end else begin
                sh_cnt <= sh_cnt - 1;
            end
        end
    end

    // Pulse counting and width monitoring (start/done must never last 2 cycles).
    always @(negedge clk) begin
        if (sh_start) start_cnt <= start_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if ((sh_start && prev_start) || (done && prev_done)) width_viol <= width_viol + 1;
        prev_start <= sh_start;
        prev_done  <= done;
    end

    // Reference: K one-bit steps as a single arithmetic shift/rotate.
    function automatic int ref_shift(int v, bit l, bit r, int k);
        int kk;
        if (r) begin
            kk = k % 4;
            if (l) return ((v << kk) | (v >> (4 - kk))) & 15;
            return ((v >> kk) | (v << (4 - kk))) & 15;
        end
        if (k >= 4) return 0;
        return l ? ((v << k) & 15) : (v >> k);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [3:0] v, input logic l, input logic r, input logic [2:0] k,
                           output logic [3:0] res, output int nstart, output int lat,
                           output logic got);
        int n;
        int s0;
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        value  = v;
        left   = l;
        rotate = r;
        amt    = k;
        valid  = 1'b1;
        s0     = start_cnt;
        @(posedge clk);
        #1 valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (done) got = 1'b1;
        end
        res    = result;
        nstart = start_cnt - s0;
    endtask

    task automatic do_check(input string tag, input logic [3:0] v, input logic l,
                            input logic r, input logic [2:0] k);
        logic [3:0] res;
        int         nstart;
        int         lat;
        logic       got;
        run_cmd(v, l, r, k, res, nstart, lat, got);
        chk({tag, "_done_seen"}, int'(got), 1);
        chk({tag, "_result"}, int'(res), ref_shift(int'(v), l, r, int'(k)));
        chk({tag, "_starts"}, nstart, int'(k));
        if (k == 3'd0) chk({tag, "_latency0"}, lat, 1);
    endtask

    initial begin
        int         n;
        int         s0;
        int         d0;
        logic [3:0] rv;
        logic       rl;
        logic       rr;
        logic [2:0] rk;

        // Reset values
        #12;
        chk("reset_outputs", int'({done, result, sh_start, sh_left, sh_rot, sh_value}), 0);
        chk("reset_ready", int'(ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed commands
        do_check("t1_l_log2", 4'b0011, 1'b1, 1'b0, 3'd2);
        do_check("t2_r_rot1", 4'b1001, 1'b0, 1'b1, 3'd1);
        do_check("t3_amt0", 4'b1010, 1'b0, 1'b0, 3'd0);
        do_check("t4_l_log5", 4'b1111, 1'b1, 1'b0, 3'd5);
        do_check("t4_r_rot6", 4'b0001, 1'b0, 1'b1, 3'd6);

        // Abort during the second WAIT of a 3-step command
        @(posedge clk);
        #1;
        value = 4'b0110; left = 1'b1; rotate = 1'b0; amt = 3'd3; valid = 1'b1;
        s0 = start_cnt;
        d0 = done_cnt;
        @(posedge clk);
        #1 valid = 1'b0;
        n = 0;
        while ((start_cnt - s0) < 2 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("abort_reach_2nd_issue", start_cnt - s0, 2);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_ready", int'(ready), 1);
        repeat (2) @(posedge clk);
        #1 force_fin = 1'b1;
        @(posedge clk);
        #1 force_fin = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_no_more_starts", start_cnt - s0, 2);
        chk("abort_idle_after_stale", int'(ready), 1);
        do_check("t5_after_abort", 4'b0001, 1'b1, 1'b0, 3'd1);

        // Abort in IDLE overrides a valid command
        @(posedge clk);
        #1;
        s0 = start_cnt;
        d0 = done_cnt;
        value = 4'b0101; amt = 3'd2; valid = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        abort = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("idle_abort_ready", int'(ready), 1);
        chk("idle_abort_no_start", start_cnt - s0, 0);
        chk("idle_abort_no_done", done_cnt - d0, 0);

        // Reset while in ISSUE
        @(posedge clk);
        #1;
        value = 4'b0101; left = 1'b1; rotate = 1'b1; amt = 3'd3; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        n = 0;
        while (!sh_start && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rst_reach_issue", int'(sh_start), 1);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", int'({done, result, sh_start, sh_left, sh_rot, sh_value}), 0);
        chk("rst_mid_ready", int'(ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_release_ready", int'(ready), 1);
        chk("rst_no_done", done_cnt - d0, 0);

        // Valid held while busy: only the first command runs
        value = 4'b0011; left = 1'b1; rotate = 1'b0; amt = 3'd2; valid = 1'b1;
        s0 = start_cnt;
        @(posedge clk);
        #1;
        value = 4'b1110; left = 1'b0; rotate = 1'b1; amt = 3'd5;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        valid = 1'b0;
        chk("hold_done_seen", int'(done), 1);
        chk("hold_result", int'(result), 12);
        chk("hold_starts", start_cnt - s0, 2);
        repeat (8) @(negedge clk);
        #1;
        chk("hold_no_second_cmd", start_cnt - s0, 2);
        chk("hold_ready", int'(ready), 1);

        // Randomized commands against the reference
        for (int i = 0; i < 25; i++) begin
            rv = 4'($urandom_range(0, 15));
            rl = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            rk = 3'($urandom_range(0, 7));
            do_check($sformatf("rand%0d", i), rv, rl, rr, rk);
        end

        chk("pulse_width_violations", width_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
